// File: rtl/muldiv_ctrl.sv
// Purpose: multi-cycle MIPS multiply/divide sequencer that feeds HI/LO writes.
// Latency: MULT/MULTU MUL_LAT+1, DIV/DIVU 33, MTHI/MTLO and divide-by-zero 1 cycle after accept.
// Backpressure: busy stalls EX while an op is in flight; flush aborts and suppresses writeback.
module muldiv_ctrl #(
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic        write_hi_en,
    output logic        write_lo_en,
    output logic [31:0] hi_data,
    output logic [31:0] lo_data
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_WB} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_signed;
    logic        r_we_hi;
    logic        r_we_lo;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic        r_neg_q;
    logic        r_neg_r;

    logic        w_accept;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_b_zero;
    logic        w_op_signed;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic [33:0] w_diff;
    logic        w_ge;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;

    // Op decode; 3'b110/3'b111 are not legal and never accepted.
    assign w_accept    = (r_state == S_IDLE) && op_valid && !flush && !(op[2] && op[1]);
    assign w_is_mul    = (op[2:1] == 2'b00);
    assign w_is_div    = (op[2:1] == 2'b01);
    assign w_b_zero    = (b == 32'd0);
    assign w_op_signed = !op[0];
    assign w_a_mag     = (w_op_signed && a[31]) ? (32'd0 - a) : a;
    assign w_b_mag     = (w_op_signed && b[31]) ? (32'd0 - b) : b;

    // Low 64 bits of the product are the same for signed/unsigned once operands are extended correctly.
    assign w_a_ext = r_signed ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
    assign w_b_ext = r_signed ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // One restoring-division step: shift next dividend bit into the partial remainder and trial-subtract.
    assign w_diff    = {1'b0, r_rem, r_quo[31]} - {2'b00, r_dvs};
    assign w_ge      = !w_diff[33];
    assign w_rem_nxt = w_ge ? w_diff[31:0] : {r_rem[30:0], r_quo[31]};
    assign w_quo_nxt = {r_quo[30:0], w_ge};

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state and writeback strobes; flush overrides everything, including a coincident WB.
    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != S_IDLE);
        done        = 1'b0;
        write_hi_en = 1'b0;
        write_lo_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_mul)                  w_state_nxt = S_MUL;
                    else if (w_is_div && !w_b_zero) w_state_nxt = S_DIV;
                    else                           w_state_nxt = S_WB;
                end
            end
            S_MUL: if (r_cnt == 8'd1) w_state_nxt = S_WB;
            S_DIV: if (r_cnt == 8'd1) w_state_nxt = S_WB;
            S_WB: begin
                done        = 1'b1;
                write_hi_en = r_we_hi;
                write_lo_en = r_we_lo;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = S_IDLE;
            done        = 1'b0;
            write_hi_en = 1'b0;
            write_lo_en = 1'b0;
        end
    end

    // Operand capture, iteration datapath and result registers; results only change on real progress.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt    <= 8'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_signed <= 1'b0;
            r_we_hi  <= 1'b0;
            r_we_lo  <= 1'b0;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_dvs    <= 32'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            hi_data  <= 32'd0;
            lo_data  <= 32'd0;
        end else if (w_accept) begin
            r_signed <= w_op_signed;
            r_we_hi  <= (op != 3'b101);
            r_we_lo  <= (op != 3'b100);
            if (w_is_mul) begin
                r_a   <= a;
                r_b   <= b;
                r_cnt <= 8'(MUL_LAT);
            end else if (w_is_div && !w_b_zero) begin
                r_quo   <= w_a_mag;
                r_dvs   <= w_b_mag;
                r_rem   <= 32'd0;
                r_neg_q <= w_op_signed && (a[31] ^ b[31]);
                r_neg_r <= w_op_signed && a[31];
                r_cnt   <= 8'd32;
            end else if (w_is_div) begin
                hi_data <= a;
                lo_data <= 32'hFFFF_FFFF;
            end else if (op == 3'b100) begin
                hi_data <= a;
            end else begin
                lo_data <= a;
            end
        end else if (!flush && r_state == S_MUL) begin
            r_cnt <= r_cnt - 8'd1;
            if (r_cnt == 8'd1) begin
                hi_data <= w_prod[63:32];
                lo_data <= w_prod[31:0];
            end
        end else if (!flush && r_state == S_DIV) begin
            r_cnt <= r_cnt - 8'd1;
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            if (r_cnt == 8'd1) begin
                lo_data <= r_neg_q ? (32'd0 - w_quo_nxt) : w_quo_nxt;
                hi_data <= r_neg_r ? (32'd0 - w_rem_nxt) : w_rem_nxt;
            end
        end
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide sequencer for the MIPS execute stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and computes products and quotients over several cycles. It drives write enables and data into the HI/LO register and holds the pipeline via `busy` while an operation is in flight.

## Interface
- `MUL_LAT`, default 1: cycles spent in MUL state (≥1); product is computed combinationally and registered on the last MUL cycle.
- `clk`  in  1  clock
- `resetn`  in  1  reset, synchronous, active-low; clock clk
- `op_valid`  in  1  EX presents an operation this cycle
- `op`  in  3  3'b000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored (no state change)
- `a`  in  32  rs operand (dividend / multiplicand / MTxx source)
- `b`  in  32  rt operand (divisor / multiplier)
- `flush`  in  1  exception/pipeline flush; aborts any operation
- `busy`  out  1  stall request; `= (state != IDLE)`
- `done`  out  1  one-cycle pulse in WB when write enables fire
- `write_hi_en`, `write_lo_en`  out  1  HI/LO write enables
- `hi_data`, `lo_data`  out  32  HI/LO write data (registered result)

## Operation
- States: IDLE, MUL, DIV, WB.
- Acceptance: only in IDLE, when `op_valid && !flush` and op legal. Operands latched on accept.
- IDLE → MUL (MULT/MULTU), counter = MUL_LAT. IDLE → DIV (DIV/DIVU, b≠0), counter = 32. IDLE → WB directly for MTHI/MTLO and for divide-by-zero.
- MUL: decrement counter; on counter==1 register {hi,lo} = 64-bit product (signed for MULT, unsigned for MULTU), → WB.
- DIV: restoring radix-2 on magnitudes, one quotient bit per cycle, 32 cycles, → WB. Signed: quotient negated if sign(a)≠sign(b); remainder takes sign of a. lo = quotient, hi = remainder.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0 (two's-complement wrap, no trap).
- Divide-by-zero (DIV and DIVU): hi = a, lo = 0xFFFFFFFF, no iterations.
- MTHI: hi_data = a, only write_hi_en. MTLO: lo_data = a, only write_lo_en. MULT/DIV: both enables.
- WB: enables and `done` high for exactly one cycle, → IDLE.
- Flush: in any state, next state = IDLE; no write enable or `done` in the flush cycle (suppresses a WB coinciding with flush); any op_valid in that cycle is ignored.
- Reset: state IDLE, counter 0, all outputs 0 (busy, done, enables, hi_data, lo_data).
- hi_data/lo_data hold last result outside WB; consumers must qualify with enables.

## Timing
- Accept at cycle T. busy rises at T+1.
- MULT/MULTU: WB at T+MUL_LAT+1 (T+2 default); busy high T+1..T+MUL_LAT+1.
- DIV/DIVU: WB at T+33; busy high T+1..T+33.
- MTHI/MTLO, divide-by-zero: WB at T+1; one stall cycle.
- busy low the cycle after WB; a new op may be accepted that cycle (back-to-back throughput = latency+1).
- Flush at cycle F: busy low at F+1; a new op is accepted at F+1.

## Test plan
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF accepted at T → at T+2, both enables, hi=0xFFFFFFFE, lo=0x00000001, done=1; busy low at T+3.
- MULT a=0xFFFFFFFD (−3) b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; repeat with MUL_LAT=3 → WB at T+4.
- DIV a=0xFFFFFFF9 (−7) b=2 → WB at T+33, lo=0xFFFFFFFD, hi=0xFFFFFFFF; busy high exactly 33 cycles. DIVU a=100 b=7 → lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=0x1234 b=0 → WB at T+1, hi=0x1234, lo=0xFFFFFFFF.
- DIV accepted at T, flush at T+10 → no enables ever for that op, busy=0 at T+11. MTLO a=0x55 issued at T+11 → write_lo_en only at T+12, lo_data=0x55. Separately, flush coincident with WB → no write.
- resetn low at T+5 of a DIV → next cycle all outputs 0, state IDLE; op_valid during reset ignored; illegal op 3'b110 in IDLE → busy stays 0.
